// File: rtl/sdram_device_model.sv
// sdram_device_model: single-rank SDRAM responder for simulation and FPGA bring-up.
// Decodes the command bus, tracks per-bank open rows, stores data in an internal
// word array, returns read data after the programmed CAS latency and raises
// sticky protocol/timing error flags.
module sdram_device_model #(
  parameter int unsigned ROW_BITS = 4,
  parameter int unsigned T_RCD    = 3,
  parameter int unsigned T_RP     = 3,
  parameter int unsigned T_RFC    = 7,
  parameter int unsigned T_REFI   = 800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sdram_cle,
  input  logic        sdram_cs,
  input  logic        sdram_ras,
  input  logic        sdram_cas,
  input  logic        sdram_we,
  input  logic        sdram_dqm,
  input  logic [1:0]  sdram_ba,
  input  logic [12:0] sdram_a,
  input  logic [31:0] dq_in,
  output logic [31:0] dq_out,
  output logic        dq_oe,
  output logic        init_done,
  output logic        err_cmd,
  output logic        err_timing,
  output logic        err_refresh
);

  localparam int unsigned NUM_BANKS = 4;
  localparam int unsigned BA_W      = 2;
  localparam int unsigned ROW_W     = 13;
  localparam int unsigned COL_W     = 6;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned IDX_W     = BA_W + ROW_BITS + COL_W;
  localparam int unsigned DEPTH     = 1 << IDX_W;
  localparam int unsigned T_MAX_A   = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int unsigned TCNT_MAX  = (T_MAX_A > T_RFC) ? T_MAX_A : T_RFC;
  localparam int unsigned TCNT_W    = $clog2(TCNT_MAX + 1);
  localparam int unsigned REFI_W    = $clog2(T_REFI + 1);

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_RD   = 4'b0101;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_TERM = 4'b0110;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_REF  = 4'b0001;
  localparam logic [3:0] CMD_LMR  = 4'b0000;

  typedef enum logic {
    BANK_IDLE   = 1'b0,
    BANK_ACTIVE = 1'b1
  } bank_st_t;

  // One slot of the CAS-latency read pipeline.
  typedef struct packed {
    logic              valid;
    logic              mask;
    logic [DATA_W-1:0] data;
  } rd_slot_t;

  bank_st_t          r_bank_st [NUM_BANKS];
  logic [ROW_W-1:0]  r_row     [NUM_BANKS];
  logic [TCNT_W-1:0] r_age     [NUM_BANKS];
  logic [TCNT_W-1:0] r_trp     [NUM_BANKS];
  logic [TCNT_W-1:0] r_rfc;
  logic [REFI_W-1:0] r_refi;
  logic [1:0]        r_cl;
  rd_slot_t          r_pipe    [3];
  logic [DATA_W-1:0] r_mem     [DEPTH];

  logic [DATA_W-1:0] r_dq_out;
  logic              r_dq_oe;
  logic              r_init_done;
  logic              r_err_cmd;
  logic              r_err_timing;
  logic              r_err_refresh;

  logic [3:0]           w_cmd;
  logic                 w_is_act;
  logic                 w_is_rd;
  logic                 w_is_wr;
  logic                 w_is_pre;
  logic                 w_is_ref;
  logic                 w_is_lmr;
  logic                 w_is_quiet;
  logic [NUM_BANKS-1:0] w_bank_open;
  logic                 w_any_open;
  logic                 w_rd_busy;
  logic                 w_tgt_open;
  logic                 w_cl_ok;
  logic [IDX_W-1:0]     w_idx;
  logic [DATA_W-1:0]    w_rd_data;
  logic [1:0]           w_ins_idx;
  rd_slot_t             w_new_slot;
  logic                 w_do_act;
  logic                 w_do_rd;
  logic                 w_do_wr;
  logic                 w_do_pre;
  logic                 w_do_ref;
  logic                 w_do_lmr;
  logic                 w_err_cmd;
  logic                 w_err_tim;
  logic                 w_unused_row;

  // Command decode, legality checks and array addressing.
  always_comb begin
    w_cmd      = {sdram_cs, sdram_ras, sdram_cas, sdram_we};
    w_is_act   = sdram_cle && (w_cmd == CMD_ACT);
    w_is_rd    = sdram_cle && (w_cmd == CMD_RD);
    w_is_wr    = sdram_cle && (w_cmd == CMD_WR);
    w_is_pre   = sdram_cle && (w_cmd == CMD_PRE);
    w_is_ref   = sdram_cle && (w_cmd == CMD_REF);
    w_is_lmr   = sdram_cle && (w_cmd == CMD_LMR);
    // Deselect, NOP and TERMINATE (burst length 1) do nothing.
    w_is_quiet = !sdram_cle || sdram_cs || (w_cmd == CMD_NOP) || (w_cmd == CMD_TERM);

    w_unused_row = 1'b0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_bank_open[b] = (r_bank_st[b] == BANK_ACTIVE);
      w_unused_row   = w_unused_row ^ (^r_row[b]);
    end
    w_any_open = |w_bank_open;
    w_rd_busy  = r_pipe[0].valid || r_pipe[1].valid || r_pipe[2].valid;
    w_tgt_open = w_bank_open[sdram_ba];
    w_cl_ok    = (sdram_a[6:4] >= 3'd1) && (sdram_a[6:4] <= 3'd3);

    w_idx      = {sdram_ba, r_row[sdram_ba][ROW_BITS-1:0], sdram_a[COL_W-1:0]};
    w_rd_data  = r_mem[w_idx];
    w_ins_idx  = r_cl - 2'd1;
    w_new_slot = '{valid: 1'b1, mask: sdram_dqm, data: w_rd_data};

    w_do_act = w_is_act && r_init_done && !w_tgt_open;
    w_do_rd  = w_is_rd && r_init_done && w_tgt_open;
    w_do_wr  = w_is_wr && r_init_done && w_tgt_open;
    w_do_pre = w_is_pre;
    w_do_ref = w_is_ref && r_init_done && !w_any_open;
    w_do_lmr = w_is_lmr && !w_any_open && !w_rd_busy && w_cl_ok;

    w_err_cmd = 1'b0;
    w_err_tim = !w_is_quiet && (r_rfc < TCNT_W'(T_RFC));
    if (w_is_act) begin
      if (!r_init_done || w_tgt_open) begin
        w_err_cmd = 1'b1;
      end else if (r_trp[sdram_ba] < TCNT_W'(T_RP)) begin
        w_err_tim = 1'b1;
      end
    end
    if (w_is_rd || w_is_wr) begin
      if (!r_init_done || !w_tgt_open) begin
        w_err_cmd = 1'b1;
      end else if (r_age[sdram_ba] < TCNT_W'(T_RCD)) begin
        w_err_tim = 1'b1;
      end
    end
    if (w_is_ref && !w_do_ref) begin
      w_err_cmd = 1'b1;
    end
    if (w_is_lmr && !w_do_lmr) begin
      w_err_cmd = 1'b1;
    end
  end

  // Bank FSMs, timing counters, read pipeline, mode register and error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        r_bank_st[b] <= BANK_IDLE;
        r_row[b]     <= '0;
        r_age[b]     <= TCNT_W'(TCNT_MAX);
        r_trp[b]     <= TCNT_W'(TCNT_MAX);
      end
      r_rfc         <= TCNT_W'(TCNT_MAX);
      r_refi        <= '0;
      r_cl          <= 2'd2;
      r_pipe[0]     <= '0;
      r_pipe[1]     <= '0;
      r_pipe[2]     <= '0;
      r_dq_out      <= '0;
      r_dq_oe       <= 1'b0;
      r_init_done   <= 1'b0;
      r_err_cmd     <= 1'b0;
      r_err_timing  <= 1'b0;
      r_err_refresh <= 1'b0;
    end else begin
      // Saturating timing counters run regardless of cle.
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (r_age[b] != TCNT_W'(TCNT_MAX)) r_age[b] <= r_age[b] + TCNT_W'(1);
        if (r_trp[b] != TCNT_W'(TCNT_MAX)) r_trp[b] <= r_trp[b] + TCNT_W'(1);
      end
      if (r_rfc != TCNT_W'(TCNT_MAX)) r_rfc <= r_rfc + TCNT_W'(1);
      if (r_init_done && (r_refi != REFI_W'(T_REFI))) r_refi <= r_refi + REFI_W'(1);

      // Read pipeline shifts toward slot 0, which feeds the output register.
      r_pipe[0] <= r_pipe[1];
      r_pipe[1] <= r_pipe[2];
      r_pipe[2] <= '0;
      if (r_pipe[0].valid) begin
        r_dq_oe  <= 1'b1;
        r_dq_out <= r_pipe[0].mask ? '0 : r_pipe[0].data;
      end else begin
        r_dq_oe  <= 1'b0;
      end
      // Inserting at slot CL-1 yields output exactly CL edges after the READ.
      if (w_do_rd) r_pipe[w_ins_idx] <= w_new_slot;

      if (w_do_act) begin
        r_bank_st[sdram_ba] <= BANK_ACTIVE;
        r_row[sdram_ba]     <= sdram_a;
        r_age[sdram_ba]     <= TCNT_W'(1);
      end
      if (w_do_pre) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
          if (sdram_a[10] || (sdram_ba == 2'(b))) begin
            r_bank_st[b] <= BANK_IDLE;
            r_trp[b]     <= TCNT_W'(1);
          end
        end
      end
      if (w_do_ref) begin
        r_rfc  <= TCNT_W'(1);
        r_refi <= '0;
      end
      if (w_do_lmr) begin
        r_cl        <= sdram_a[5:4];
        r_init_done <= 1'b1;
      end

      if (w_err_cmd) r_err_cmd    <= 1'b1;
      if (w_err_tim) r_err_timing <= 1'b1;
      if (r_init_done && !w_do_ref && (r_refi == REFI_W'(T_REFI))) r_err_refresh <= 1'b1;
    end
  end

  // Storage array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_do_wr && !sdram_dqm) r_mem[w_idx] <= dq_in;
  end

  assign dq_out      = r_dq_out;
  assign dq_oe       = r_dq_oe;
  assign init_done   = r_init_done;
  assign err_cmd     = r_err_cmd;
  assign err_timing  = r_err_timing;
  assign err_refresh = r_err_refresh;

endmodule
